// File: rtl/kgp_ctrl_fsm_if.sv
// rtl/kgp_ctrl_fsm_if.sv - instruction/data memory handshake bundle for kgp_ctrl_fsm
interface kgp_ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/kgp_ctrl_fsm.sv
// rtl/kgp_ctrl_fsm.sv - KGP_RISC multi-cycle control FSM; optional perf counters under KGP_CTRL_PERF_EN
module kgp_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [1:0]  opcode,
    input  logic [3:0]  func,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        flag_s,
    kgp_ctrl_fsm_if.master mem,
    output logic        ir_load,
    output logic        alu_en,
    output logic        alu_src,
    output logic        flag_write,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        halted,
    output logic        err
`ifdef KGP_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    // Timeout fires on the cycle the counter would reach MEM_TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       taken_q;
    logic       err_q;
    logic       set_err;
    logic       cond;
    logic       imem_req_c;
    logic       dmem_req_c;
    logic       dmem_we_c;

    assign state        = state_q;
    assign halted       = (state_q == HALT);
    assign err          = err_q;
    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;

    always_comb begin
        cond = 1'b0;
        if (!func[3]) begin
            case (func[2:0])
                3'b000:  cond = 1'b1;
                3'b001:  cond = flag_z;
                3'b010:  cond = !flag_z;
                3'b011:  cond = flag_c;
                3'b100:  cond = !flag_c;
                3'b101:  cond = flag_s;
                3'b110:  cond = !flag_s;
                default: cond = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_next;
            if (state_next != state_q) begin
                wait_cnt <= '0;
            end else if (state_q == FETCH || state_q == MEM) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state_q == EXEC) begin
                taken_q <= (opcode == 2'b11) && cond;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_q;
        set_err    = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_load    = 1'b0;
        alu_en     = 1'b0;
        alu_src    = 1'b0;
        flag_write = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                imem_req_c = 1'b1;
                ir_load    = mem.imem_ack;
                if (mem.imem_ack) begin
                    state_next = DECODE;
                end else if (wait_cnt == TMO_LAST) begin
                    state_next = HALT;
                    set_err    = 1'b1;
                end
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                alu_en     = 1'b1;
                alu_src    = (opcode != 2'b00);
                flag_write = !opcode[1];
                if (opcode == 2'b10) begin
                    state_next = MEM;
                end else if (opcode == 2'b11 && func == 4'b1111) begin
                    state_next = HALT;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = func[0];
                if (mem.dmem_ack) begin
                    state_next = WB;
                end else if (wait_cnt == TMO_LAST) begin
                    state_next = HALT;
                    set_err    = 1'b1;
                end
            end
            WB: begin
                pc_write   = 1'b1;
                instr_done = 1'b1;
                reg_write  = !opcode[1] || (opcode == 2'b10 && !func[0]);
                wb_sel     = (opcode == 2'b10) && !func[0];
                if (opcode == 2'b11 && taken_q) begin
                    pc_src = (func == 4'b0111) ? 2'b10 : 2'b01;
                end
                state_next = run ? FETCH : IDLE;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
                set_err    = 1'b1;
            end
        endcase
    end

`ifdef KGP_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state_q != IDLE && state_q != HALT) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (instr_done) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// tb/tb_kgp_ctrl_fsm.sv - scoreboard bench for kgp_ctrl_fsm (MEM_TIMEOUT=4)
module tb_kgp_ctrl_fsm;

    localparam logic [15:0] IMRQ = 16'h8000;
    localparam logic [15:0] IRLD = 16'h4000;
    localparam logic [15:0] ALU  = 16'h2000;
    localparam logic [15:0] ASRC = 16'h1000;
    localparam logic [15:0] FLW  = 16'h0800;
    localparam logic [15:0] DMRQ = 16'h0400;
    localparam logic [15:0] DMWE = 16'h0200;
    localparam logic [15:0] RGW  = 16'h0100;
    localparam logic [15:0] WBS  = 16'h0080;
    localparam logic [15:0] PCW  = 16'h0040;
    localparam logic [15:0] PC10 = 16'h0020;
    localparam logic [15:0] PC01 = 16'h0010;
    localparam logic [15:0] DONE = 16'h0008;
    localparam logic [15:0] HLT  = 16'h0004;
    localparam logic [15:0] ERR  = 16'h0002;

    logic        clk;
    logic        rst;
    logic        run;
    logic [1:0]  opcode;
    logic [3:0]  func;
    logic        flag_z;
    logic        flag_c;
    logic        flag_s;
    logic        ir_load;
    logic        alu_en;
    logic        alu_src;
    logic        flag_write;
    logic        reg_write;
    logic        wb_sel;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  dut_state;
    logic        instr_done;
    logic        halted;
    logic        err;
`ifdef KGP_CTRL_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic        perf_probe;
    logic [31:0] exp_cycles;
    logic [31:0] exp_instrs;
`endif

    kgp_ctrl_fsm_if mif ();

    kgp_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .func       (func),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_s     (flag_s),
        .mem        (mif.master),
        .ir_load    (ir_load),
        .alu_en     (alu_en),
        .alu_src    (alu_src),
        .flag_write (flag_write),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .state      (dut_state),
        .instr_done (instr_done),
        .halted     (halted),
        .err        (err)
`ifdef KGP_CTRL_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    logic [18:0] exp_q[$];
    int          compared;
    int          mismatched;
    logic        probe;
    logic        check_empty;
    int          imem_wait;
    int          dmem_wait;
    int          icnt;
    int          dcnt;
    logic [18:0] mon_cur;
    logic [18:0] mon_exp;

    logic [3:0]  br_func [5] = '{4'b0001, 4'b0001, 4'b0111, 4'b1000, 4'b0100};
    logic        br_z    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] br_pc   [5] = '{16'h0010, 16'h0000, 16'h0020, 16'h0000, 16'h0010};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic [2:0] st, input logic [15:0] f);
        exp_q.push_back({st, f});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_probe();
        push(3'd0, 16'h0000);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        tick();
        check_empty = 1'b1;
        @(negedge clk);
        #1;
        check_empty = 1'b0;
    endtask

    // Memory responder: ack after the configured number of wait cycles.
    initial begin
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        icnt = 0;
        dcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mif.imem_req) begin
                mif.imem_ack = (icnt >= imem_wait);
                icnt++;
            end else begin
                mif.imem_ack = 1'b0;
                icnt = 0;
            end
            if (mif.dmem_req) begin
                mif.dmem_ack = (dcnt >= dmem_wait);
                dcnt++;
            end else begin
                mif.dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        mon_cur = {dut_state, mif.imem_req, ir_load, alu_en, alu_src, flag_write,
                   mif.dmem_req, mif.dmem_we, reg_write, wb_sel, pc_write, pc_src,
                   instr_done, halted, err, 1'b0};
        if (dut_state != 3'd0 || mon_cur[15:0] != 16'h0 || probe) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output got state=%0d out=%h required none", mon_cur[18:16], mon_cur[15:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_cur !== mon_exp) begin
                    mismatched++;
                    $display("FAIL trace t=%0t got state=%0d out=%h required state=%0d out=%h",
                             $time, mon_cur[18:16], mon_cur[15:0], mon_exp[18:16], mon_exp[15:0]);
                end
            end
        end
        if (check_empty) begin
            compared++;
            if (exp_q.size() != 0) begin
                mismatched++;
                $display("FAIL drained got %0d pending required 0", exp_q.size());
                exp_q.delete();
            end
        end
`ifdef KGP_CTRL_PERF_EN
        if (perf_probe) begin
            compared += 2;
            if (cycle_count !== exp_cycles) begin
                mismatched++;
                $display("FAIL cycle_count got %0d required %0d", cycle_count, exp_cycles);
            end
            if (instr_count !== exp_instrs) begin
                mismatched++;
                $display("FAIL instr_count got %0d required %0d", instr_count, exp_instrs);
            end
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        run = 1'b0;
        opcode = 2'b00;
        func = 4'b0000;
        flag_z = 1'b0;
        flag_c = 1'b0;
        flag_s = 1'b0;
        probe = 1'b0;
        check_empty = 1'b0;
        imem_wait = 0;
        dmem_wait = 0;
`ifdef KGP_CTRL_PERF_EN
        perf_probe = 1'b0;
        exp_cycles = 32'd12;
        exp_instrs = 32'd3;
`endif
        tick();
        tick();
        rst = 1'b0;
        idle_probe();

        // Three back-to-back ALU reg-reg instructions
        opcode = 2'b00;
        func = 4'b0010;
        repeat (3) begin
            push(3'd1, IMRQ | IRLD);
            push(3'd2, 16'h0);
            push(3'd3, ALU | FLW);
            push(3'd5, PCW | RGW | DONE);
        end
        run = 1'b1;
        tick();
        repeat (8) tick();
        run = 1'b0;
        drain(30);
`ifdef KGP_CTRL_PERF_EN
        perf_probe = 1'b1;
        @(negedge clk);
        #1;
        perf_probe = 1'b0;
`endif

        // Load with dmem_ack on the 4th MEM cycle (same cycle as the timeout limit)
        opcode = 2'b10;
        func = 4'b0000;
        dmem_wait = 3;
        push(3'd1, IMRQ | IRLD);
        push(3'd2, 16'h0);
        push(3'd3, ALU | ASRC);
        repeat (4) push(3'd4, DMRQ);
        push(3'd5, PCW | RGW | WBS | DONE);
        run = 1'b1;
        tick();
        run = 1'b0;
        drain(30);

        // Store
        func = 4'b0001;
        dmem_wait = 0;
        push(3'd1, IMRQ | IRLD);
        push(3'd2, 16'h0);
        push(3'd3, ALU | ASRC);
        push(3'd4, DMRQ | DMWE);
        push(3'd5, PCW | DONE);
        run = 1'b1;
        tick();
        run = 1'b0;
        drain(30);

        // Branches: taken/not-taken, register-indirect, reserved
        opcode = 2'b11;
        for (int b = 0; b < 5; b++) begin
            func = br_func[b];
            flag_z = br_z[b];
            flag_c = 1'b0;
            push(3'd1, IMRQ | IRLD);
            push(3'd2, 16'h0);
            push(3'd3, ALU | ASRC);
            push(3'd5, PCW | DONE | br_pc[b]);
            run = 1'b1;
            tick();
            run = 1'b0;
            drain(30);
        end

        // ALU immediate, run dropped during EXEC
        opcode = 2'b01;
        func = 4'b0011;
        push(3'd1, IMRQ | IRLD);
        push(3'd2, 16'h0);
        push(3'd3, ALU | ASRC | FLW);
        push(3'd5, PCW | RGW | DONE);
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        drain(30);

        // Reset during EXEC abandons the instruction
        opcode = 2'b00;
        push(3'd1, IMRQ | IRLD);
        push(3'd2, 16'h0);
        push(3'd3, ALU | FLW);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drain(5);
        idle_probe();

        // Halt instruction: HALT without err, held until reset
        opcode = 2'b11;
        func = 4'b1111;
        push(3'd1, IMRQ | IRLD);
        push(3'd2, 16'h0);
        push(3'd3, ALU | ASRC);
        repeat (3) push(3'd6, HLT);
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drain(5);
        idle_probe();

        // Instruction fetch timeout
        opcode = 2'b00;
        func = 4'b0000;
        imem_wait = 1000;
        repeat (4) push(3'd1, IMRQ);
        repeat (2) push(3'd6, HLT | ERR);
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_wait = 0;
        drain(5);
        idle_probe();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
